// File: rtl/sysid_check_ctrl.sv
// Reads the sysid slave's ID (addr 0) then timestamp (addr 1) and flags each against its expected value.
// done fires 2*READ_LATENCY+3 cycles after start is sampled; define SYSID_CHECK_CTRL_AUTOSTART_EN to run one check after every reset release.
module sysid_check_ctrl #(
   parameter logic [31:0] EXPECTED_ID        = 32'd4919,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1537363031,
   parameter int unsigned READ_LATENCY       = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata
);

   localparam logic [3:0] LAST_WAIT = 4'(READ_LATENCY);

   typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

   state_t     state;
   logic [3:0] wait_cnt;
   logic       go;

`ifdef SYSID_CHECK_CTRL_AUTOSTART_EN
   // Set by reset, consumed by the first clock edge after release.
   logic auto_pend;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) auto_pend <= 1'b1;
      else          auto_pend <= 1'b0;
   end

   assign go = start | auto_pend;
`else
   assign go = start;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         wait_cnt      <= 4'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         id_ok         <= 1'b0;
         ts_ok         <= 1'b0;
         id_value      <= 32'd0;
         ts_value      <= 32'd0;
         sysid_address <= 1'b0;
         sysid_read    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state         <= RD_ID;
                  wait_cnt      <= 4'd0;
                  busy          <= 1'b1;
                  sysid_read    <= 1'b1;
                  sysid_address <= 1'b0;
               end
            end
            RD_ID: begin
               if (wait_cnt == LAST_WAIT) begin
                  id_value      <= sysid_readdata;
                  state         <= RD_TS;
                  wait_cnt      <= 4'd0;
                  sysid_address <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RD_TS: begin
               // id_value was captured on the RD_ID exit edge, so it is stable here.
               if (wait_cnt == LAST_WAIT) begin
                  ts_value      <= sysid_readdata;
                  id_ok         <= (id_value == EXPECTED_ID);
                  ts_ok         <= (sysid_readdata == EXPECTED_TIMESTAMP);
                  state         <= DONE;
                  wait_cnt      <= 4'd0;
                  busy          <= 1'b0;
                  sysid_read    <= 1'b0;
                  sysid_address <= 1'b0;
                  done          <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            DONE: begin
               done     <= 1'b0;
               wait_cnt <= 4'd0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
- REQ-001 SHALL have parameter EXPECTED_ID, default 4919: system ID value compared on read of address 0.
- REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 1537363031: timestamp compared on read of address 1.
- REQ-003 SHALL have parameter READ_LATENCY, default 0, legal range 0..15: wait cycles between presenting an address and sampling sysid_readdata.
- REQ-004 SHALL have port clock, input, 1: single clock; all state changes on rising edge.
- REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
- REQ-006 SHALL have port start, input, 1: check request, sampled only in IDLE.
- REQ-007 SHALL have port busy, output, 1: high in RD_ID and RD_TS.
- REQ-008 SHALL have port done, output, 1: one-cycle pulse, high only in DONE.
- REQ-009 SHALL have port id_ok, output, 1: last captured ID equals EXPECTED_ID.
- REQ-010 SHALL have port ts_ok, output, 1: last captured timestamp equals EXPECTED_TIMESTAMP.
- REQ-011 SHALL have port id_value, output, 32: last captured ID word.
- REQ-012 SHALL have port ts_value, output, 32: last captured timestamp word.
- REQ-013 SHALL have port sysid_address, output, 1: word address to the sysid slave.
- REQ-014 SHALL have port sysid_read, output, 1: read strobe to the sysid slave.
- REQ-015 SHALL have port sysid_readdata, input, 32: read data from the sysid slave; combinational relative to sysid_address.

Function
- REQ-016 SHALL implement states IDLE, RD_ID, RD_TS, DONE, plus a 4-bit wait counter.
- REQ-017 SHALL transition IDLE->RD_ID on an edge where start=1; otherwise remain in IDLE.
- REQ-018 SHALL, in RD_ID, drive sysid_address=0, sysid_read=1 for READ_LATENCY+1 cycles, capture sysid_readdata into id_value on the last edge, then go to RD_TS.
- REQ-019 SHALL, in RD_TS, drive sysid_address=1, sysid_read=1 for READ_LATENCY+1 cycles, capture into ts_value on the last edge, then go to DONE.
- REQ-020 SHALL clear the wait counter on every state entry; counter never wraps because the state exits at READ_LATENCY.
- REQ-021 SHALL update id_ok and ts_ok on the edge entering DONE, holding them until the next DONE entry.
- REQ-022 SHALL stay in DONE exactly one cycle, then return to IDLE unconditionally.
- REQ-023 SHALL ignore start in RD_ID, RD_TS and DONE (no queuing); start held high continuously yields back-to-back checks with one IDLE cycle between.
- REQ-024 SHALL drive sysid_read=0 and sysid_address=0 in IDLE and DONE.
- REQ-025 SHALL assert done 2*READ_LATENCY+3 cycles after the edge sampling start.
- REQ-026 SHALL compare full 32-bit words; no masking.

Reset
- REQ-027 SHALL, on reset_n=0, immediately force state IDLE, counter 0, and busy, done, id_ok, ts_ok, sysid_read, sysid_address to 0, id_value and ts_value to 0.
- REQ-028 SHALL abandon any in-progress check on reset mid-operation, with no done pulse.

Configuration
- REQ-029 SHALL honour macro SYSID_CHECK_CTRL_AUTOSTART_EN: when defined, the first edge after reset_n deasserts moves IDLE->RD_ID without start, exactly once per reset; when undefined, checks begin only on start.

Verification
- REQ-030 SHALL cover: READ_LATENCY=0, slave returns 4919/1537363031, start pulse at edge 0 -> sysid_read high cycles 1-2 (address 0 then 1), done at cycle 3, id_ok=1, ts_ok=1.
- REQ-031 SHALL cover: slave returns 0x00001338 at address 0 -> id_value=0x00001338, id_ok=0, ts_ok=1.
- REQ-032 SHALL cover: READ_LATENCY=3, start pulse -> sysid_read high 8 consecutive cycles, done 9 cycles after start edge.
- REQ-033 SHALL cover: start held high 12 cycles, READ_LATENCY=0 -> done pulses every 4 cycles; start pulse during RD_TS -> no extra check.
- REQ-034 SHALL cover: reset_n low during RD_TS -> all outputs 0 without waiting for a clock edge, no done after release (macro undefined).
- REQ-035 SHALL cover: macro defined, no start -> exactly one done within 2*READ_LATENCY+4 cycles of reset release, then none.
